// File: rtl/gsim_mat_fetch.sv
// Fetch stage for the Gauss-Seidel solver: streams N matrices (17 words each) from matrix memory
// into a small credit-limited FIFO and out over a valid/ready stream tagged with word/matrix index.
module gsim_mat_fetch #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 256,
    parameter int WPM        = 17,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [4:0]        i_matrix_num,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_mem_rreq,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_rrdy,
    input  logic [DATA_W-1:0] i_mem_dout,
    input  logic              i_mem_dout_vld,
    output logic              o_word_vld,
    output logic [DATA_W-1:0] o_word_data,
    output logic [4:0]        o_word_idx,
    output logic              o_word_last,
    output logic [4:0]        o_mat_idx,
    input  logic              i_word_rdy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   issued_r;
    logic [ADDR_W-1:0]   total_r;
    logic [ADDR_W-1:0]   total_s;
    logic [CNT_W-1:0]    outst_r;
    logic [CNT_W-1:0]    fifo_cnt_r;
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [DATA_W-1:0]   mem_r [FIFO_DEPTH];
    logic [4:0]          word_idx_r;
    logic [4:0]          mat_idx_r;
    logic                done_r;
    logic                err_r;

    logic                start_ok_s;
    logic                credit_s;
    logic                rreq_s;
    logic                req_acc_s;
    logic                push_s;
    logic                pop_s;

    assign start_ok_s = i_start && (state_r == ST_IDLE);
    assign total_s    = ADDR_W'(i_matrix_num) * ADDR_W'(WPM);
    // Reads in flight plus buffered words never exceed the FIFO depth, so no return can be lost.
    assign credit_s   = ({1'b0, outst_r} + {1'b0, fifo_cnt_r}) < (CNT_W + 1)'(FIFO_DEPTH);
    assign rreq_s     = (state_r == ST_FETCH) && (issued_r < total_r) && credit_s;
    assign req_acc_s  = rreq_s && i_mem_rrdy;
    assign push_s     = i_mem_dout_vld && (outst_r != CNT_W'(0));
    assign pop_s      = (fifo_cnt_r != CNT_W'(0)) && i_word_rdy;

    // Next-state decode for the fetch sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    if (i_matrix_num == 5'd0) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_FETCH;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (issued_r >= total_r) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if ((outst_r == CNT_W'(0)) && (fifo_cnt_r == CNT_W'(0))) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State register plus the done pulse and sticky error flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            done_r  <= (state_r == ST_DONE);
            if (i_mem_dout_vld && (outst_r == CNT_W'(0))) begin
                err_r <= 1'b1;
            end
        end
    end

    // Request address, target count and stream position counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            issued_r   <= '0;
            total_r    <= '0;
            word_idx_r <= 5'd0;
            mat_idx_r  <= 5'd0;
        end else if (start_ok_s) begin
            issued_r   <= '0;
            total_r    <= total_s;
            word_idx_r <= 5'd0;
            mat_idx_r  <= 5'd0;
        end else begin
            if (req_acc_s) begin
                issued_r <= issued_r + ADDR_W'(1);
            end
            if (pop_s) begin
                if (word_idx_r == 5'(WPM - 1)) begin
                    word_idx_r <= 5'd0;
                    mat_idx_r  <= mat_idx_r + 5'd1;
                end else begin
                    word_idx_r <= word_idx_r + 5'd1;
                end
            end
        end
    end

    // Outstanding-read and FIFO occupancy bookkeeping; simultaneous inc/dec cancel.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            outst_r    <= '0;
            fifo_cnt_r <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
        end else begin
            case ({req_acc_s, push_s})
                2'b10:   outst_r <= outst_r + CNT_W'(1);
                2'b01:   outst_r <= outst_r - CNT_W'(1);
                default: outst_r <= outst_r;
            endcase
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_W'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_W'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // FIFO storage, cleared on reset so the stream data output reads zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= i_mem_dout;
        end
    end

    assign o_busy      = (state_r == ST_FETCH) || (state_r == ST_DRAIN);
    assign o_done      = done_r;
    assign o_err       = err_r;
    assign o_mem_rreq  = rreq_s;
    assign o_mem_addr  = issued_r;
    assign o_word_vld  = (fifo_cnt_r != CNT_W'(0));
    assign o_word_data = mem_r[rd_ptr_r];
    assign o_word_idx  = word_idx_r;
    assign o_word_last = (word_idx_r == 5'(WPM - 1));
    assign o_mat_idx   = mat_idx_r;

endmodule

// File: tb/tb_gsim_mat_fetch.sv
// Self-checking bench for gsim_mat_fetch: a queue-based memory model with random latency and
// backpressure, and a scoreboard deriving every expected word from its position in the stream.
module tb_gsim_mat_fetch;

    localparam int WPM   = 17;
    localparam int DEPTH = 4;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         i_start;
    logic [4:0]   i_matrix_num;
    logic         o_busy;
    logic         o_done;
    logic         o_err;
    logic         o_mem_rreq;
    logic [9:0]   o_mem_addr;
    logic         i_mem_rrdy;
    logic [255:0] i_mem_dout;
    logic         i_mem_dout_vld;
    logic         o_word_vld;
    logic [255:0] o_word_data;
    logic [4:0]   o_word_idx;
    logic         o_word_last;
    logic [4:0]   o_mat_idx;
    logic         i_word_rdy;

    gsim_mat_fetch dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_start        (i_start),
        .i_matrix_num   (i_matrix_num),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_err          (o_err),
        .o_mem_rreq     (o_mem_rreq),
        .o_mem_addr     (o_mem_addr),
        .i_mem_rrdy     (i_mem_rrdy),
        .i_mem_dout     (i_mem_dout),
        .i_mem_dout_vld (i_mem_dout_vld),
        .o_word_vld     (o_word_vld),
        .o_word_data    (o_word_data),
        .o_word_idx     (o_word_idx),
        .o_word_last    (o_word_last),
        .o_mat_idx      (o_mat_idx),
        .i_word_rdy     (i_word_rdy)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int req_cnt, word_cnt, done_cnt, exp_total;
    int rrdy_pct, rdy_pct, hold_cnt, lat_min, lat_max;
    bit inject_vld;
    int pend_addr[$];
    int pend_due[$];
    logic [31:0] seed;
    bit stall_prev;
    logic [255:0] prev_data;
    logic [4:0] prev_idx, prev_mat;

    // Memory image: every word is a distinct function of its address and a per-run seed.
    function automatic logic [255:0] mem_word(int a);
        logic [255:0] w;
        for (int i = 0; i < 8; i++) begin
            w[i*32 +: 32] = 32'((a + 1) * 32'h9E3779B1) ^ seed ^ 32'(i * 32'h01010101);
        end
        return w;
    endfunction

    // One clock cycle: drive inputs at the falling edge, score what the next rising edge will do.
    task automatic step();
        int lat;
        i_mem_rrdy = ($urandom_range(99) < rrdy_pct);
        if (hold_cnt > 0) begin
            i_word_rdy = 1'b0;
            hold_cnt--;
        end else begin
            i_word_rdy = ($urandom_range(99) < rdy_pct);
        end
        if (inject_vld) begin
            i_mem_dout_vld = 1'b1;
            i_mem_dout = {8{$urandom}};
        end else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            i_mem_dout_vld = 1'b1;
            i_mem_dout = mem_word(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            i_mem_dout_vld = 1'b0;
            i_mem_dout = '0;
        end
        if (stall_prev) begin
            checks++;
            if (o_word_vld !== 1'b1 || o_word_data !== prev_data || o_word_idx !== prev_idx || o_mat_idx !== prev_mat)
                begin errors++; $display("FAIL stall_stable: vld=%b idx=%0d mat=%0d, required held idx=%0d mat=%0d", o_word_vld, o_word_idx, o_mat_idx, prev_idx, prev_mat); end
        end
        if (o_mem_rreq === 1'b1) begin
            checks++;
            if (req_cnt - word_cnt >= DEPTH || req_cnt >= exp_total)
                begin errors++; $display("FAIL credit: rreq with %0d in flight/buffered, %0d of %0d issued", req_cnt - word_cnt, req_cnt, exp_total); end
            if (i_mem_rrdy) begin
                checks++;
                if (o_mem_addr !== 10'(req_cnt))
                    begin errors++; $display("FAIL req_addr: got %0d, required %0d", o_mem_addr, req_cnt); end
                lat = $urandom_range(lat_max, lat_min);
                pend_addr.push_back(req_cnt);
                pend_due.push_back(cyc + lat);
                req_cnt++;
            end
        end
        stall_prev = o_word_vld && !i_word_rdy;
        prev_data = o_word_data;
        prev_idx = o_word_idx;
        prev_mat = o_mat_idx;
        if (o_word_vld === 1'b1 && i_word_rdy) begin
            checks++;
            if (word_cnt >= exp_total) begin
                errors++; $display("FAIL extra_word: word %0d beyond total %0d", word_cnt, exp_total);
            end else if (o_word_data !== mem_word(word_cnt) || o_word_idx !== 5'(word_cnt % WPM) ||
                         o_mat_idx !== 5'(word_cnt / WPM) || o_word_last !== (word_cnt % WPM == WPM - 1)) begin
                errors++;
                $display("FAIL word: #%0d got idx=%0d mat=%0d last=%b data=%h, required idx=%0d mat=%0d last=%b data=%h",
                         word_cnt, o_word_idx, o_mat_idx, o_word_last, o_word_data[63:0],
                         word_cnt % WPM, word_cnt / WPM, (word_cnt % WPM == WPM - 1), mem_word(word_cnt)[63:0]);
            end
            word_cnt++;
        end
        if (o_done === 1'b1) begin
            checks++;
            if (word_cnt != exp_total)
                begin errors++; $display("FAIL done_early: done with %0d words, required %0d", word_cnt, exp_total); end
            done_cnt++;
        end
        @(posedge i_clk);
        cyc++;
        @(negedge i_clk);
    endtask

    task automatic start_run(int n);
        req_cnt = 0; word_cnt = 0; done_cnt = 0; exp_total = n * WPM;
        seed = $urandom; stall_prev = 1'b0;
        i_matrix_num = 5'(n);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic finish_run(int budget, string name);
        while (done_cnt == 0 && budget > 0) begin
            step();
            budget--;
        end
        checks++;
        if (done_cnt == 0) begin errors++; $display("FAIL %s_timeout: no done pulse, required one", name); end
        repeat (3) step();
        checks++;
        if (req_cnt !== exp_total || word_cnt !== exp_total || done_cnt !== 1)
            begin errors++; $display("FAIL %s_totals: req=%0d words=%0d done=%0d, required %0d/%0d/1", name, req_cnt, word_cnt, done_cnt, exp_total, exp_total); end
        checks++;
        if (o_busy !== 1'b0 || o_err !== 1'b0 || pend_addr.size() != 0)
            begin errors++; $display("FAIL %s_end: busy=%b err=%b pending=%0d, required 0/0/0", name, o_busy, o_err, pend_addr.size()); end
    endtask

    task automatic check_zero_outputs(string name);
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_err !== 1'b0 || o_mem_rreq !== 1'b0 || o_mem_addr !== 10'd0 ||
            o_word_vld !== 1'b0 || o_word_data !== 256'd0 || o_word_idx !== 5'd0 || o_word_last !== 1'b0 || o_mat_idx !== 5'd0)
            begin errors++; $display("FAIL %s: busy=%b done=%b err=%b rreq=%b addr=%0d vld=%b idx=%0d mat=%0d, required all 0",
                                     name, o_busy, o_done, o_err, o_mem_rreq, o_mem_addr, o_word_vld, o_word_idx, o_mat_idx); end
    endtask

    task automatic apply_reset();
        i_rst_n = 1'b0;
        i_start = 1'b0; i_mem_dout_vld = 1'b0; i_mem_dout = '0; inject_vld = 1'b0;
        pend_addr.delete(); pend_due.delete(); stall_prev = 1'b0; hold_cnt = 0;
        #1;
        check_zero_outputs("reset_outputs");
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        i_matrix_num = 5'd0; i_mem_rrdy = 1'b0; i_word_rdy = 1'b0;
        apply_reset();
    endtask

    task automatic test_single_matrix();
        rrdy_pct = 100; rdy_pct = 100; lat_min = 2; lat_max = 2;
        start_run(1);
        finish_run(200, "single");
    endtask

    task automatic test_backpressure();
        rrdy_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 3;
        hold_cnt = 20;
        start_run(2);
        repeat (19) step();
        checks++;
        if (req_cnt !== DEPTH || o_mem_rreq !== 1'b0)
            begin errors++; $display("FAIL backpressure_cap: %0d accepted rreq=%b, required %0d and 0", req_cnt, o_mem_rreq, DEPTH); end
        finish_run(400, "backpressure");
    endtask

    task automatic test_random_latency();
        rrdy_pct = 50; rdy_pct = 100; lat_min = 1; lat_max = 5;
        start_run(3);
        finish_run(2000, "random_latency");
    endtask

    task automatic test_zero_matrices();
        rrdy_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
        start_run(0);
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL zero_c1: done=%b busy=%b, required 0/0", o_done, o_busy); end
        step();
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL zero_c2: done=%b busy=%b, required 1/0", o_done, o_busy); end
        step();
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL zero_c3: done=%b busy=%b, required 0/0", o_done, o_busy); end
        finish_run(10, "zero");
    endtask

    task automatic test_reset_abort();
        int budget = 500;
        rrdy_pct = 80; rdy_pct = 80; lat_min = 1; lat_max = 4;
        start_run(2);
        while (word_cnt < 9 && budget > 0) begin step(); budget--; end
        checks++;
        if (word_cnt != 9) begin errors++; $display("FAIL abort_reach: %0d words before reset, required 9", word_cnt); end
        apply_reset();
        start_run(1);
        finish_run(400, "restart");
    endtask

    task automatic test_random_sizes();
        for (int r = 0; r < 3; r++) begin
            rrdy_pct = $urandom_range(90, 30); rdy_pct = $urandom_range(90, 30);
            lat_min = 1; lat_max = $urandom_range(6, 1);
            start_run($urandom_range(5, 1));
            finish_run(4000, "random_size");
        end
    endtask

    task automatic test_stray_return();
        rrdy_pct = 100; rdy_pct = 100;
        exp_total = 0; word_cnt = 0;
        inject_vld = 1'b1;
        step();
        inject_vld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (o_err !== 1'b1 || o_word_vld !== 1'b0)
                begin errors++; $display("FAIL stray_err: cycle %0d err=%b vld=%b, required 1/0", i, o_err, o_word_vld); end
            step();
        end
        apply_reset();
    endtask

    initial begin
        hold_cnt = 0; inject_vld = 1'b0; exp_total = 0; req_cnt = 0; word_cnt = 0; done_cnt = 0;
        rrdy_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1; seed = 32'd0; stall_prev = 1'b0;
        @(negedge i_clk);
        test_reset();
        test_single_matrix();
        test_backpressure();
        test_random_latency();
        test_zero_matrices();
        test_reset_abort();
        test_random_sizes();
        test_stray_return();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
